// File: rtl/pcileech_bar_impl_ahci_mp.sv
// AHCI HBA register mimic for a PCIe BAR: global HBA registers plus NUM_PORTS ports,
// each with a ST/CR command engine, FRE/FR follower, timed COMRESET link-up and W1C status.
module pcileech_bar_impl_ahci_mp #(
  parameter int         NUM_PORTS   = 2,
  parameter logic [7:0] DEV_PRESENT = 8'h01,
  parameter int         HR_CYCLES   = 64,
  parameter int         ST_CYCLES   = 8,
  parameter int         FR_CYCLES   = 4,
  parameter int         LINK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic [87:0] rd_req_ctx,
  input  logic [31:0] rd_req_addr,
  input  logic        rd_req_valid,
  output logic [87:0] rd_rsp_ctx,
  output logic [31:0] rd_rsp_data,
  output logic        rd_rsp_valid,
  output logic        irq
);
  localparam int NP    = NUM_PORTS;
  localparam int MAX_A = (HR_CYCLES > ST_CYCLES) ? HR_CYCLES : ST_CYCLES;
  localparam int MAX_B = (FR_CYCLES > LINK_CYCLES) ? FR_CYCLES : LINK_CYCLES;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAXC > 0) ? $clog2(MAXC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [31:0] CAP_VAL = 32'hC734FF00 | 32'(NP - 1);
  localparam logic [31:0] PI_VAL  = 32'((64'h1 << NP) - 64'h1);

  typedef enum logic [1:0] {IDLE, STARTING, RUNNING, STOPPING} cmd_state_e;

  // Handshake: no backpressure; wr_valid and rd_req_valid are single-clk strobes,
  // rd_rsp_valid/rd_rsp_ctx repeat rd_req_valid/rd_req_ctx exactly one clk later.
  logic             ae, ie, hr;
  logic [CNT_W-1:0] hr_cnt;
  logic [NP-1:0]    is_r;

  logic [31:0]      clb [NP];
  logic [31:0]      clbu[NP];
  logic [31:0]      fb  [NP];
  logic [31:0]      fbu [NP];
  logic [31:0]      pxis[NP];
  logic [31:0]      pxie[NP];
  logic [31:0]      serr[NP];
  logic [7:0]       tfd [NP];
  logic [11:0]      ssts[NP];
  logic [3:0]       sctl[NP];
  cmd_state_e       cmd_state[NP];
  logic [CNT_W-1:0] cmd_cnt [NP];
  logic [CNT_W-1:0] fr_cnt  [NP];
  logic [CNT_W-1:0] link_cnt[NP];
  logic [NP-1:0]    st, fre, fr, cr, fr_pend, link_act;

  logic [11:0]   wa, ra;
  logic [6:0]    wp_off;
  logic [4:0]    wp_idx, rp_idx;
  logic [31:0]   bm, rd_data;
  logic          wr_ok, wp_hit, ghc_wr, hr_done;
  logic [NP-1:0] is_clr, pw, cmd_wr, st_new, fre_new, sctl_wr, det_set, det_clr;
  logic [NP-1:0] link_fire, pend_set;
  logic          unused_addr;

  assign wa      = wr_addr[11:0];
  assign ra      = rd_req_addr[11:0];
  assign wp_off  = wa[6:0];
  assign wp_idx  = wa[11:7] - 5'd2;
  assign rp_idx  = ra[11:7] - 5'd2;
  assign bm      = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
  assign wr_ok   = wr_valid && !hr;
  assign wp_hit  = wr_ok && (wa[11:8] != 4'h0) && (wp_idx < 5'(NP));
  assign ghc_wr  = wr_valid && (wa == 12'h004);
  assign hr_done = hr && (hr_cnt <= CNT_ONE);
  assign is_clr  = (wr_ok && (wa == 12'h008) && wr_be[0]) ? wr_data[NP-1:0] : '0;
  assign irq     = ie && (|is_r);
  assign unused_addr = &{1'b0, wr_addr[31:12], rd_req_addr[31:12]};

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] data,
                                           input logic [31:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

  always_comb begin
    pw = '0; cmd_wr = '0; st_new = '0; fre_new = '0; sctl_wr = '0;
    det_set = '0; det_clr = '0; link_fire = '0; pend_set = '0;
    for (int p = 0; p < NP; p++) begin
      pw[p]        = wp_hit && (wp_idx == 5'(p));
      cmd_wr[p]    = pw[p] && (wp_off == 7'h18) && wr_be[0];
      st_new[p]    = cmd_wr[p] ? wr_data[0] : st[p];
      fre_new[p]   = cmd_wr[p] ? wr_data[4] : fre[p];
      sctl_wr[p]   = pw[p] && (wp_off == 7'h2C) && wr_be[0];
      det_set[p]   = sctl_wr[p] && (wr_data[3:0] == 4'h1);
      det_clr[p]   = sctl_wr[p] && (wr_data[3:0] == 4'h0) && (sctl[p] == 4'h1) && DEV_PRESENT[p];
      link_fire[p] = link_act[p] && (link_cnt[p] <= CNT_ONE) && !det_set[p];
      pend_set[p]  = |(pxis[p] & pxie[p]);
    end
  end

  always_comb begin
    rd_data = '0;
    if (ra[11:8] == 4'h0) begin
      case (ra[7:0])
        8'h00:   rd_data = CAP_VAL;
        8'h04:   rd_data = {ae, 29'h0, ie, hr};
        8'h08:   rd_data = 32'(is_r);
        8'h0C:   rd_data = PI_VAL;
        8'h10:   rd_data = 32'h00010301;
        default: rd_data = '0;
      endcase
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (rp_idx == 5'(p)) begin
          case (ra[6:0])
            7'h00:   rd_data = clb[p];
            7'h04:   rd_data = clbu[p];
            7'h08:   rd_data = fb[p];
            7'h0C:   rd_data = fbu[p];
            7'h10:   rd_data = pxis[p];
            7'h14:   rd_data = pxie[p];
            7'h18:   rd_data = {16'h0, cr[p], fr[p], 9'h0, fre[p], 3'h0, st[p]};
            7'h20:   rd_data = {24'h0, tfd[p]};
            7'h28:   rd_data = {20'h0, ssts[p]};
            7'h2C:   rd_data = {28'h0, sctl[p]};
            7'h30:   rd_data = serr[p];
            default: rd_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_ctx   <= '0;
      rd_rsp_data  <= '0;
      ae <= 1'b0; ie <= 1'b0; hr <= 1'b0; hr_cnt <= '0; is_r <= '0;
    end else begin
      rd_rsp_valid <= rd_req_valid;
      rd_rsp_ctx   <= rd_req_ctx;
      rd_rsp_data  <= rd_req_valid ? rd_data : 32'h0;
      if (ghc_wr && wr_be[3]) ae <= wr_data[31];
      if (ghc_wr && wr_be[0]) ie <= wr_data[1];
      // A running HBA reset is never restarted; expiry overrides a same-clk IE write.
      if (hr) begin
        if (hr_done) begin
          hr <= 1'b0;
          ie <= 1'b0;
        end else begin
          hr_cnt <= hr_cnt - CNT_ONE;
        end
      end else if (ghc_wr && wr_be[0] && wr_data[0]) begin
        hr     <= 1'b1;
        hr_cnt <= CNT_W'(HR_CYCLES);
      end
      if (hr_done) is_r <= '0;
      else         is_r <= (is_r & ~is_clr) | pend_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0; fre <= '0; fr <= '0; cr <= '0; fr_pend <= '0; link_act <= '0;
      for (int p = 0; p < NP; p++) begin
        clb[p] <= '0; clbu[p] <= '0; fb[p] <= '0; fbu[p] <= '0;
        pxis[p] <= '0; pxie[p] <= '0; serr[p] <= '0; sctl[p] <= '0;
        tfd[p]  <= DEV_PRESENT[p] ? 8'h50 : 8'h00;
        ssts[p] <= DEV_PRESENT[p] ? 12'h133 : 12'h000;
        cmd_state[p] <= IDLE; cmd_cnt[p] <= '0; fr_cnt[p] <= '0; link_cnt[p] <= '0;
      end
    end else if (hr_done) begin
      st <= '0; fre <= '0; fr <= '0; cr <= '0; fr_pend <= '0; link_act <= '0;
      for (int p = 0; p < NP; p++) begin
        clb[p] <= '0; clbu[p] <= '0; fb[p] <= '0; fbu[p] <= '0;
        pxis[p] <= '0; pxie[p] <= '0; serr[p] <= '0; sctl[p] <= '0;
        tfd[p]  <= DEV_PRESENT[p] ? 8'h50 : 8'h00;
        ssts[p] <= DEV_PRESENT[p] ? 12'h133 : 12'h000;
        cmd_state[p] <= IDLE; cmd_cnt[p] <= '0; fr_cnt[p] <= '0; link_cnt[p] <= '0;
      end
    end else begin
      st  <= st_new;
      fre <= fre_new;
      for (int p = 0; p < NP; p++) begin
        if (pw[p]) begin
          case (wp_off)
            7'h00:   clb[p]  <= be_merge(clb[p], wr_data, bm);
            7'h04:   clbu[p] <= be_merge(clbu[p], wr_data, bm);
            7'h08:   fb[p]   <= be_merge(fb[p], wr_data, bm);
            7'h0C:   fbu[p]  <= be_merge(fbu[p], wr_data, bm);
            7'h14:   pxie[p] <= be_merge(pxie[p], wr_data, bm);
            default: ;
          endcase
        end
        // Hardware set is OR-ed in after the W1C clear, so a same-clk set wins.
        pxis[p] <= (pxis[p] & ~((pw[p] && wp_off == 7'h10) ? (wr_data & bm) : 32'h0))
                 | (link_fire[p] ? 32'h00000041 : 32'h0);
        serr[p] <= (serr[p] & ~((pw[p] && wp_off == 7'h30) ? (wr_data & bm) : 32'h0))
                 | (link_fire[p] ? 32'h04010000 : 32'h0);
        if (sctl_wr[p]) sctl[p] <= wr_data[3:0];

        if (det_set[p]) begin
          ssts[p] <= 12'h000;
          tfd[p]  <= 8'h80;
          link_act[p] <= 1'b0;
        end else if (det_clr[p]) begin
          link_act[p] <= 1'b1;
          link_cnt[p] <= CNT_W'(LINK_CYCLES);
        end else if (link_fire[p]) begin
          link_act[p] <= 1'b0;
          ssts[p] <= 12'h133;
          tfd[p]  <= 8'h50;
        end else if (link_act[p]) begin
          link_cnt[p] <= link_cnt[p] - CNT_ONE;
        end

        if (fre_new[p] != fre[p]) begin
          fr_pend[p] <= 1'b1;
          fr_cnt[p]  <= CNT_W'(FR_CYCLES);
        end else if (fr_pend[p]) begin
          if (fr_cnt[p] <= CNT_ONE) begin
            fr[p]      <= fre[p];
            fr_pend[p] <= 1'b0;
          end else begin
            fr_cnt[p] <= fr_cnt[p] - CNT_ONE;
          end
        end

        case (cmd_state[p])
          IDLE: if (st_new[p]) begin
            cmd_state[p] <= STARTING;
            cmd_cnt[p]   <= CNT_W'(ST_CYCLES);
          end
          STARTING: begin
            if (!st_new[p]) begin
              cmd_state[p] <= IDLE;
            end else if (cmd_cnt[p] <= CNT_ONE) begin
              cmd_state[p] <= RUNNING;
              cr[p] <= 1'b1;
            end else begin
              cmd_cnt[p] <= cmd_cnt[p] - CNT_ONE;
            end
          end
          RUNNING: if (!st_new[p]) begin
            cmd_state[p] <= STOPPING;
            cmd_cnt[p]   <= CNT_W'(ST_CYCLES);
          end
          STOPPING: begin
            if (cmd_cnt[p] <= CNT_ONE) begin
              cmd_state[p] <= IDLE;
              cr[p] <= 1'b0;
            end else begin
              cmd_cnt[p] <= cmd_cnt[p] - CNT_ONE;
            end
          end
          default: cmd_state[p] <= IDLE;
        endcase
      end
    end
  end
endmodule
